// File: rtl/generic_width_packer.sv
// -----------------------------------------------------------------------------
// generic_width_packer
//
// Narrow-to-wide stream packer. Collects RATIO beats of W_IN bits and presents
// them as one W_OUT = W_IN*RATIO word. Beat k of a word occupies bits
// [k*W_IN +: W_IN]. Valid/ready handshake on both sides. When the consumer
// keeps i_ready high, one input beat is taken every cycle with no bubbles.
//
// Optional feature macro: GENERIC_WIDTH_PACKER_FLUSH_EN
//   defined   -> i_flush port present; a partially filled word can be emitted
//   undefined -> no i_flush port, every emitted word holds exactly RATIO beats
//
// Ports
//   i_clk    in   1      clock, rising edge
//   i_rst    in   1      asynchronous reset, active-low
//   i_valid  in   1      input beat valid
//   o_ready  out  1      packer accepts i_data this cycle
//   i_data   in   W_IN   input beat
//   i_flush  in   1      emit partial word (flush build only)
//   o_valid  out  1      packed word valid (registered)
//   i_ready  in   1      consumer takes o_data this cycle
//   o_data   out  W_OUT  packed word
//   o_count  out  W_CNT  number of valid beats in o_data (registered)
//
// State | Meaning
// ------+----------------------------------------------------------------
// FILL  | collecting beats into lanes, o_valid=0, always ready
// HOLD  | full (or flushed) word presented, o_valid=1, ready follows i_ready
// -----------------------------------------------------------------------------
module generic_width_packer #(
  parameter  int W_IN  = 1,
  parameter  int RATIO = 4,
  localparam int W_OUT = W_IN * RATIO,
  localparam int W_CNT = $clog2(RATIO + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W_IN-1:0]  i_data,
`ifdef GENERIC_WIDTH_PACKER_FLUSH_EN
  input  logic             i_flush,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W_OUT-1:0] o_data,
  output logic [W_CNT-1:0] o_count
);

  localparam int W_IDX = $clog2(RATIO);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [W_IDX-1:0]   idx_q, idx_d;
  logic [W_OUT-1:0]   data_q, data_d;
  logic [W_CNT-1:0]   count_q, count_d;
  logic               accept;
  logic               drain;
  logic               flush_go;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_valid = (state_q == S_HOLD);
    // While holding, a beat can only be taken in the cycle the word leaves.
    o_ready = (state_q == S_FILL) ? 1'b1 : i_ready;
    o_data  = data_q;
    o_count = count_q;
  end

  assign accept = i_valid & o_ready;
  assign drain  = (state_q == S_HOLD) & i_ready;

`ifdef GENERIC_WIDTH_PACKER_FLUSH_EN
  // Flushing an empty packer is a no-op; a beat arriving with the flush
  // counts as content and is packed before emission.
  assign flush_go = i_flush & (state_q == S_FILL) & ((idx_q != '0) | accept);
`else
  assign flush_go = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          for (int k = 0; k < RATIO; k++) begin
            if (idx_q == W_IDX'(k)) begin
              data_d[k*W_IN +: W_IN] = i_data;
            end
          end
          if (idx_q == W_IDX'(RATIO - 1)) begin
            state_d = S_HOLD;
            count_d = W_CNT'(RATIO);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + W_IDX'(1);
          end
        end
        if (flush_go && (state_d == S_FILL)) begin
          state_d = S_HOLD;
          count_d = W_CNT'(idx_q) + W_CNT'(accept);
          idx_d   = '0;
        end
      end

      S_HOLD: begin
        if (drain) begin
          state_d = S_FILL;
          count_d = '0;
          // Clearing on drain keeps unwritten lanes of the next word at zero.
          data_d  = '0;
          idx_d   = '0;
          if (accept) begin
            data_d[W_IN-1:0] = i_data;
            idx_d            = W_IDX'(1);
          end
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

endmodule
